// File: rtl/sa_out_deskew.sv
// Deskews the systolic array's bottom-row output into aligned rows and queues them for writeback.
// Optional define OB_RELU_EN rectifies negative elements as they are written into the FIFO.
module sa_out_deskew #(
  parameter int unsigned N_COL   = 4,
  parameter int unsigned L_WIDTH = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         OB_clk,
  input  logic                         OB_rst,
  input  logic                         OB_clear,
  input  logic                         OB_mode,
  input  logic [N_COL-1:0]             OB_en_in,
  input  logic [N_COL*L_WIDTH-1:0]     OB_data_in,
  input  logic [15:0]                  OB_cfg_rows,
  output logic                         OB_out_valid,
  input  logic                         OB_out_ready,
  output logic [N_COL*L_WIDTH-1:0]     OB_out_data,
  output logic                         OB_out_last,
  output logic                         OB_done,
  output logic                         OB_ovf,
  output logic                         OB_skew_err,
  output logic [$clog2(DEPTH+1)-1:0]   OB_count
);

  localparam int unsigned DW = N_COL * L_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic             sclr;
  logic [N_COL-1:0] qual;
  logic [N_COL-1:0] av;
  logic [DW-1:0]    ad;
  logic [DW-1:0]    wdata;

  assign sclr = OB_rst | OB_clear;
  assign qual = OB_en_in & ~{N_COL{OB_mode}};

  // Column c is delayed N_COL-1-c cycles so every column of a row meets the last one.
  for (genvar c = 0; c < N_COL; c++) begin : g_col
    localparam int unsigned DLY = N_COL - 1 - c;
    if (DLY == 0) begin : g_direct
      assign av[c]                   = qual[c];
      assign ad[c*L_WIDTH +: L_WIDTH] = OB_data_in[c*L_WIDTH +: L_WIDTH];
    end else begin : g_dly
      logic [DLY-1:0]     v_q;
      logic [L_WIDTH-1:0] d_q [DLY];
      always_ff @(posedge OB_clk) begin
        if (sclr) begin
          v_q <= '0;
          for (int i = 0; i < DLY; i++) d_q[i] <= '0;
        end else begin
          v_q[0] <= qual[c];
          d_q[0] <= OB_data_in[c*L_WIDTH +: L_WIDTH];
          for (int i = 1; i < DLY; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end
      assign av[c]                    = v_q[DLY-1];
      assign ad[c*L_WIDTH +: L_WIDTH] = d_q[DLY-1];
    end
  end

  always_comb begin
    wdata = ad;
`ifdef OB_RELU_EN
    for (int c = 0; c < N_COL; c++) begin
      if (ad[c*L_WIDTH + L_WIDTH - 1]) wdata[c*L_WIDTH +: L_WIDTH] = '0;
    end
`endif
  end

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   rowcnt_q, rowcnt_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic [DW-1:0] head_q, head_d;
  logic          done_q, ovf_q, skew_q;
  logic          all_v, any_v, full, pop, push, drop, last_pop;

  // Head, valid and last are kept as registers so the output face is glitch-free.
  always_comb begin
    all_v    = &av;
    any_v    = |av;
    full     = (count_q == CW'(DEPTH));
    pop      = valid_q & OB_out_ready;
    last_pop = pop & last_q;
    push     = all_v & (~full | pop);
    drop     = all_v & full & ~pop;
    wp_d     = wp_q + PW'(push);
    rp_d     = rp_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    rowcnt_d = rowcnt_q;
    if (pop) rowcnt_d = last_pop ? 16'd0 : rowcnt_q + 16'd1;
    valid_d  = (count_d != '0);
    head_d   = '0;
    if (valid_d) head_d = (push && (wp_q == rp_d)) ? wdata : mem[rp_d];
    last_d   = valid_d & (OB_cfg_rows != 16'd0) & (rowcnt_d == OB_cfg_rows - 16'd1);
  end

  always_ff @(posedge OB_clk) begin
    if (push) mem[wp_q] <= wdata;
  end

  always_ff @(posedge OB_clk) begin
    if (sclr) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      rowcnt_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      skew_q   <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      rowcnt_q <= rowcnt_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      last_q   <= last_d;
      done_q   <= last_pop;
      ovf_q    <= ovf_q | drop;
      skew_q   <= skew_q | (any_v & ~all_v);
    end
  end

  assign OB_out_valid = valid_q;
  assign OB_out_data  = head_q;
  assign OB_out_last  = last_q;
  assign OB_done      = done_q;
  assign OB_ovf       = ovf_q;
  assign OB_skew_err  = skew_q;
  assign OB_count     = count_q;

endmodule

// File: tb/tb_sa_out_deskew.sv
// Randomized bench for sa_out_deskew against a row-level queue model of the deskew stage and FIFO.
module tb_sa_out_deskew;

  localparam int unsigned N_COL   = 4;
  localparam int unsigned L_WIDTH = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DW      = N_COL * L_WIDTH;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned HS      = 16;

  logic             clk = 1'b0;
  logic             rst, clear, mode, ready;
  logic [N_COL-1:0] en;
  logic [DW-1:0]    din;
  logic [15:0]      cfg_rows;
  logic             out_valid, out_last, done, ovf, skew_err;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  sa_out_deskew #(.N_COL(N_COL), .L_WIDTH(L_WIDTH), .DEPTH(DEPTH)) dut (
    .OB_clk(clk), .OB_rst(rst), .OB_clear(clear), .OB_mode(mode),
    .OB_en_in(en), .OB_data_in(din), .OB_cfg_rows(cfg_rows),
    .OB_out_valid(out_valid), .OB_out_ready(ready), .OB_out_data(out_data),
    .OB_out_last(out_last), .OB_done(done), .OB_ovf(ovf),
    .OB_skew_err(skew_err), .OB_count(count)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  // Stimulus schedule: per cycle, which columns present which data.
  logic [N_COL-1:0] sch_en [HS];
  logic [DW-1:0]    sch_d  [HS];
  // Model: history of qualified inputs, FIFO contents, row index and flags.
  logic [N_COL-1:0] h_v [HS];
  logic [DW-1:0]    h_d [HS];
  logic [DW-1:0]    mq [$];
  int unsigned      m_rowcnt;
  bit               m_done, m_ovf, m_skew;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] r);
    logic [DW-1:0] o;
    o = r;
`ifdef OB_RELU_EN
    for (int c = 0; c < N_COL; c++)
      if (r[c*L_WIDTH + L_WIDTH - 1]) o[c*L_WIDTH +: L_WIDTH] = '0;
`endif
    return o;
  endfunction

  task automatic sched_row(input int unsigned t0, input logic [DW-1:0] row, input logic [N_COL-1:0] cols);
    for (int c = 0; c < N_COL; c++) begin
      if (cols[c]) begin
        sch_en[(t0 + c) % HS][c]                    = 1'b1;
        sch_d[(t0 + c) % HS][c*L_WIDTH +: L_WIDTH] = row[c*L_WIDTH +: L_WIDTH];
      end
    end
  endtask

  task automatic flush_sched();
    for (int i = 0; i < HS; i++) begin
      sch_en[i] = '0;
      sch_d[i]  = '0;
    end
  endtask

  task automatic model_step();
    logic [N_COL-1:0] v;
    logic [DW-1:0]    row;
    bit               pop, last;
    if (rst || clear) begin
      mq.delete();
      m_rowcnt = 0;
      m_done = 0; m_ovf = 0; m_skew = 0;
      for (int k = 0; k < N_COL; k++) h_v[(cyc + HS - k) % HS] = '0;
      return;
    end
    h_v[cyc % HS] = en & ~{N_COL{mode}};
    h_d[cyc % HS] = din;
    for (int c = 0; c < N_COL; c++) begin
      int unsigned idx;
      idx = (cyc + HS - (N_COL - 1 - c)) % HS;
      v[c] = h_v[idx][c];
      row[c*L_WIDTH +: L_WIDTH] = h_d[idx][c*L_WIDTH +: L_WIDTH];
    end
    pop  = (mq.size() != 0) && ready;
    last = pop && (cfg_rows != 0) && (m_rowcnt == cfg_rows - 1);
    if (pop) begin
      void'(mq.pop_front());
      m_rowcnt = last ? 0 : m_rowcnt + 1;
    end
    if (&v) begin
      if (mq.size() < DEPTH) mq.push_back(relu(row));
      else m_ovf = 1;
    end else if (|v) begin
      m_skew = 1;
    end
    m_done = last;
  endtask

  task automatic tick();
    en  = sch_en[cyc % HS];
    din = sch_d[cyc % HS];
    sch_en[cyc % HS] = '0;
    sch_d[cyc % HS]  = '0;
    model_step();
    @(posedge clk);
    #1;
    check("count", DW'(count), DW'(mq.size()));
    check("valid", DW'(out_valid), DW'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("data", out_data, mq[0]);
      check("last", DW'(out_last), DW'((cfg_rows != 0) && (m_rowcnt == cfg_rows - 1)));
    end
    check("done", DW'(done), DW'(m_done));
    check("ovf", DW'(ovf), DW'(m_ovf));
    check("skew", DW'(skew_err), DW'(m_skew));
    cyc++;
  endtask

  task automatic do_reset(input logic [15:0] rows);
    flush_sched();
    cfg_rows = rows;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] mkrow(input int a, input int b, input int c, input int d);
    logic [DW-1:0] r;
    r[0*L_WIDTH +: L_WIDTH] = L_WIDTH'(a);
    r[1*L_WIDTH +: L_WIDTH] = L_WIDTH'(b);
    r[2*L_WIDTH +: L_WIDTH] = L_WIDTH'(c);
    r[3*L_WIDTH +: L_WIDTH] = L_WIDTH'(d);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int c = 0; c < N_COL; c++) r[c*L_WIDTH +: L_WIDTH] = $urandom;
    return r;
  endfunction

  initial begin
    int unsigned t0;
    logic [DW-1:0] exp_row;
    rst = 1'b1; clear = 1'b0; mode = 1'b0; ready = 1'b1;
    en = '0; din = '0; cfg_rows = 16'd3;
    for (int i = 0; i < HS; i++) begin h_v[i] = '0; h_d[i] = '0; end
    flush_sched();
    m_rowcnt = 0; m_done = 0; m_ovf = 0; m_skew = 0;

    do_reset(16'd3);
    check("rst_data", out_data, '0);

    // Three skewed rows streamed with ready held high; tile of 3 rows.
    t0 = cyc;
    sched_row(t0,     mkrow(1, 2, 3, 4),    '1);
    sched_row(t0 + 1, mkrow(5, 6, 7, 8),    '1);
    sched_row(t0 + 2, mkrow(9, 10, 11, 12), '1);
    for (int i = 0; i < 4; i++) tick();
    check("row1_first", out_data, mkrow(1, 2, 3, 4));
    for (int i = 0; i < 6; i++) tick();

    // Back-pressure: five rows into a four-deep FIFO, then drain.
    do_reset(16'd0);
    ready = 1'b0;
    t0 = cyc;
    for (int r = 0; r < 5; r++) sched_row(t0 + r, rand_row(), '1);
    for (int i = 0; i < 10; i++) tick();
    check("ovf_full_count", DW'(count), DW'(DEPTH));
    ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Full FIFO, ready rises exactly as the next row lands.
    do_reset(16'd0);
    ready = 1'b0;
    t0 = cyc;
    for (int r = 0; r < 4; r++) sched_row(t0 + r, rand_row(), '1);
    sched_row(t0 + 6, rand_row(), '1);
    while (cyc < t0 + 9) tick();
    ready = 1'b1;
    tick();
    check("full_pushpop_ovf", DW'(ovf), '0);
    for (int i = 0; i < 6; i++) tick();

    // Missing column in the middle row.
    do_reset(16'd0);
    t0 = cyc;
    sched_row(t0,     rand_row(), '1);
    sched_row(t0 + 1, rand_row(), 4'b1011);
    sched_row(t0 + 2, rand_row(), '1);
    for (int i = 0; i < 8; i++) tick();

    // Weight-store traffic, then mode rising mid-row.
    do_reset(16'd0);
    mode = 1'b1;
    sched_row(cyc, {N_COL{32'h7F}}, '1);
    for (int i = 0; i < 6; i++) tick();
    mode = 1'b0;
    t0 = cyc;
    sched_row(t0, rand_row(), '1);
    tick(); tick();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mode = 1'b0;

    // Signed row through the optional rectifier.
    do_reset(16'd0);
    ready = 1'b0;
    sched_row(cyc, mkrow(-5, 3, -1, 0), '1);
    for (int i = 0; i < 5; i++) tick();
`ifdef OB_RELU_EN
    exp_row = mkrow(0, 3, 0, 0);
`else
    exp_row = mkrow(-5, 3, -1, 0);
`endif
    check("relu_row", out_data, exp_row);

    // Reset landing in the middle of that row.
    do_reset(16'd0);
    ready = 1'b1;
    t0 = cyc;
    sched_row(t0, mkrow(-5, 3, -1, 0), '1);
    tick(); tick();
    flush_sched();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_data", out_data, '0);

    // Randomized traffic.
    do_reset(16'd5);
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 0) begin
        cfg_rows = 16'($urandom_range(0, 6));
        clear = 1'b1;
        flush_sched();
        tick();
        clear = 1'b0;
      end
      if ($urandom_range(0, 255) == 0) begin
        clear = 1'b1;
        flush_sched();
        tick();
        clear = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        logic [N_COL-1:0] cols;
        cols = '1;
        if ($urandom_range(0, 31) == 0) cols[$urandom_range(0, N_COL - 1)] = 1'b0;
        sched_row(cyc, rand_row(), cols);
      end
      ready = ($urandom_range(0, 9) < 7);
      mode  = ($urandom_range(0, 63) == 0);
      tick();
    end
    mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
